// File: rtl/swap_pkg.sv
// Shared constants for the memory-swap responder: controller step codes,
// phase-tracker encodings and a saturating counter helper.
package swap_pkg;

    // Step select values driven by the swap controller on sel
    localparam logic [1:0] SEL_IDLE       = 2'd0;
    localparam logic [1:0] SEL_LOAD_TMP   = 2'd1;
    localparam logic [1:0] SEL_A_FROM_B   = 2'd2;
    localparam logic [1:0] SEL_B_FROM_TMP = 2'd3;

    // Phase tracker encodings; 2'd3 is unused and treated as a fault
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_EXP2 = 2'd1;
    localparam logic [1:0] PH_EXP3 = 2'd2;

    // Width of the optional completed-swap counter
    localparam int CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/swap_regfile.sv
// Register file for the swap responder: 2**ADDR_W words of DATA_W bits,
// one write port, two combinational read ports used by the swap steps and
// one registered read-before-write host read port.
module swap_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Storage array and host read register; every word clears on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_data_r <= '0;
        end else begin
            // Read samples the pre-edge contents, so same-address writes
            // are seen on the following read only
            rd_data_r <= mem_r[rd_addr];
            if (we) begin
                mem_r[waddr] <= wdata;
            end
        end
    end

    assign ra_data = mem_r[ra_addr];
    assign rb_data = mem_r[rb_addr];
    assign rd_data = rd_data_r;

endmodule

// File: rtl/swap_datapath.sv
// Memory-swap responder. Follows the controller's three-step w/sel
// sequence (load temp, copy b->a, write temp->b) against an internal
// register file, offers a host write/read port, and flags out-of-order
// steps in a sticky seq_err.
// Optional build macro SWAP_COUNT_EN adds a saturating swap_count output.
module swap_datapath
    import swap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              w,
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              seq_err,
    input  logic              clr_err
`ifdef SWAP_COUNT_EN
    ,
    output logic [CNT_W-1:0]  swap_count
`endif
);

    logic [1:0]        phase_r;
    logic [1:0]        phase_nxt_s;
    logic [DATA_W-1:0] temp_r;
    logic [ADDR_W-1:0] a_q_r;
    logic [ADDR_W-1:0] b_q_r;
    logic              done_r;
    logic              seq_err_r;

    logic              load_tmp_s;
    logic              copy_s;
    logic              finish_s;
    logic              viol_s;
    logic              host_we_s;

    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    // Step decode: which step (if any) fires this cycle and the next phase
    always_comb begin
        phase_nxt_s = phase_r;
        load_tmp_s  = 1'b0;
        copy_s      = 1'b0;
        finish_s    = 1'b0;
        viol_s      = 1'b0;
        case (phase_r)
            PH_IDLE: begin
                if (w) begin
                    if (sel == SEL_LOAD_TMP) begin
                        load_tmp_s  = 1'b1;
                        phase_nxt_s = PH_EXP2;
                    end else begin
                        viol_s      = 1'b1;
                        phase_nxt_s = PH_IDLE;
                    end
                end else begin
                    phase_nxt_s = PH_IDLE;
                end
            end
            PH_EXP2: begin
                if (w && (sel == SEL_A_FROM_B)) begin
                    copy_s      = 1'b1;
                    phase_nxt_s = PH_EXP3;
                end else begin
                    viol_s      = 1'b1;
                    phase_nxt_s = PH_IDLE;
                end
            end
            PH_EXP3: begin
                if (w && (sel == SEL_B_FROM_TMP)) begin
                    finish_s    = 1'b1;
                    phase_nxt_s = PH_IDLE;
                end else begin
                    viol_s      = 1'b1;
                    phase_nxt_s = PH_IDLE;
                end
            end
            default: begin
                // Unreachable encoding: recover to IDLE and report it
                viol_s      = 1'b1;
                phase_nxt_s = PH_IDLE;
            end
        endcase
    end

    // Host writes only land while no swap is in flight; step 1 never
    // writes the array, so it can share the cycle with a host write
    assign host_we_s = wr_en && (phase_r == PH_IDLE);

    // Single write port arbitration between swap steps 2/3 and the host
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = wr_data;
        if (copy_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = a_q_r;
            mem_wdata_s = rd_b_s;
        end else if (finish_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = b_q_r;
            mem_wdata_s = temp_r;
        end else if (host_we_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wr_addr;
            mem_wdata_s = wr_data;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    swap_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mem_we_s),
        .waddr   (mem_waddr_s),
        .wdata   (mem_wdata_s),
        .ra_addr (addr_a),
        .ra_data (rd_a_s),
        .rb_addr (b_q_r),
        .rb_data (rd_b_s),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Phase tracker register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= PH_IDLE;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Step 1 captures the word at addr_a and latches both addresses so
    // later steps ignore any change on addr_a/addr_b
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            temp_r <= '0;
            a_q_r  <= '0;
            b_q_r  <= '0;
        end else if (load_tmp_s) begin
            temp_r <= rd_a_s;
            a_q_r  <= addr_a;
            b_q_r  <= addr_b;
        end
    end

    // Completion pulse, one cycle after step 3
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_r <= 1'b0;
        end else begin
            done_r <= finish_s;
        end
    end

    // Sticky violation flag; a new violation outranks a clear request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_err_r <= 1'b0;
        end else if (viol_s) begin
            seq_err_r <= 1'b1;
        end else if (clr_err) begin
            seq_err_r <= 1'b0;
        end
    end

`ifdef SWAP_COUNT_EN
    logic [CNT_W-1:0] swap_count_r;

    // Completed-swap counter, saturating, cleared alongside seq_err
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            swap_count_r <= '0;
        end else if (clr_err) begin
            swap_count_r <= '0;
        end else if (done_r) begin
            swap_count_r <= sat_inc(swap_count_r);
        end
    end

    assign swap_count = swap_count_r;
`endif

    assign busy    = (phase_r != PH_IDLE);
    assign done    = done_r;
    assign seq_err = seq_err_r;

endmodule

// File: tb/tb_swap_datapath.sv
// Self-checking bench for swap_datapath: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_swap_datapath;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          w       = 1'b0;
    logic [1:0]    sel     = 2'd0;
    logic [AW-1:0] addr_a  = '0;
    logic [AW-1:0] addr_b  = '0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          seq_err;
`ifdef SWAP_COUNT_EN
    logic [15:0]   swap_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: array contents, the step number expected next
    // (1, 2 or 3), the pending swap and the observable outputs
    logic [DW-1:0] m_mem [8];
    logic [DW-1:0] m_tmp;
    logic [AW-1:0] m_a, m_b;
    int            m_next;
    logic [DW-1:0] m_rd;
    logic          m_done, m_err;
    logic [15:0]   m_cnt;

    always #5 clk = ~clk;

    swap_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .w       (w),
        .sel     (sel),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .seq_err (seq_err),
        .clr_err (clr_err)
`ifdef SWAP_COUNT_EN
        ,
        .swap_count (swap_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_tmp = '0; m_a = '0; m_b = '0; m_next = 1;
        m_rd = '0; m_done = 1'b0; m_err = 1'b0; m_cnt = '0;
    endtask

    // One clock edge of the reference behaviour, using the current inputs
    task automatic model_step();
        logic viol;
        viol = 1'b0;
        m_rd = m_mem[rd_addr];
        if (clr_err) m_cnt = '0;
        else if (m_done && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_done = 1'b0;
        if (m_next == 1) begin
            if (w && sel == 2'd1) begin
                m_tmp = m_mem[addr_a]; m_a = addr_a; m_b = addr_b; m_next = 2;
            end else if (w) begin
                viol = 1'b1;
            end
            if (wr_en) m_mem[wr_addr] = wr_data;
        end else if (m_next == 2) begin
            if (w && sel == 2'd2) begin
                m_mem[m_a] = m_mem[m_b]; m_next = 3;
            end else begin
                viol = 1'b1;
            end
        end else begin
            if (w && sel == 2'd3) begin
                m_mem[m_b] = m_tmp; m_next = 1; m_done = 1'b1;
            end else begin
                viol = 1'b1;
            end
        end
        if (viol) begin
            m_next = 1; m_err = 1'b1;
        end else if (clr_err) begin
            m_err = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("rd_data", rd_data, m_rd);
        chk("busy", busy, m_next != 1);
        chk("done", done, m_done);
        chk("seq_err", seq_err, m_err);
`ifdef SWAP_COUNT_EN
        chk("swap_count", swap_count, m_cnt);
`endif
    endtask

    task automatic step(input logic ww, input logic [1:0] s);
        w = ww; sel = s;
        tick();
        w = 1'b0; sel = 2'd0; wr_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic swap(input logic [AW-1:0] a, input logic [AW-1:0] b);
        addr_a = a; addr_b = b;
        step(1'b1, 2'd1); step(1'b1, 2'd2); step(1'b1, 2'd3);
    endtask

    task automatic hwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_addr = a;
        tick();
        chk(tag, rd_data, exp);
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err_clears", seq_err, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_seq_err", seq_err, 1'b0);
        reset_n = 1'b1;

        // Basic 2<->5 swap with step-by-step busy/done checks
        hwrite(3'd2, 8'hA5);
        hwrite(3'd5, 8'h3C);
        addr_a = 3'd2; addr_b = 3'd5;
        step(1'b1, 2'd1); chk("busy_after_s1", busy, 1'b1);
        step(1'b1, 2'd2); chk("busy_after_s2", busy, 1'b1);
        step(1'b1, 2'd3); chk("busy_after_s3", busy, 1'b0);
        chk("done_after_s3", done, 1'b1);
        rd("swap_mem2", 3'd2, 8'h3C);
        chk("done_one_cycle", done, 1'b0);
        rd("swap_mem5", 3'd5, 8'hA5);

        // Self-swap leaves contents intact and still completes
        hwrite(3'd4, 8'h77);
        swap(3'd4, 3'd4);
        chk("self_swap_done", done, 1'b1);
        rd("self_swap_mem4", 3'd4, 8'h77);
        chk("self_swap_err", seq_err, 1'b0);

        // Address inputs changing after step 1 are ignored
        addr_a = 3'd2; addr_b = 3'd5;
        step(1'b1, 2'd1);
        addr_a = 3'd0; addr_b = 3'd1;
        step(1'b1, 2'd2); step(1'b1, 2'd3);
        rd("latch_mem0", 3'd0, 8'h00);
        rd("latch_mem1", 3'd1, 8'h00);
        rd("latch_mem2", 3'd2, 8'hA5);
        rd("latch_mem5", 3'd5, 8'h3C);

        // Skipping step 2 is a violation; clear, then a clean swap works
        addr_a = 3'd2; addr_b = 3'd5;
        step(1'b1, 2'd1);
        step(1'b1, 2'd3);
        chk("skip_err", seq_err, 1'b1);
        chk("skip_busy", busy, 1'b0);
        rd("skip_mem5", 3'd5, 8'h3C);
        clear_err();
        swap(3'd2, 3'd5);
        chk("recover_done", done, 1'b1);
        rd("recover_mem2", 3'd2, 8'h3C);

        // Host write during step 2 is dropped
        addr_a = 3'd2; addr_b = 3'd5;
        step(1'b1, 2'd1);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hFF;
        step(1'b1, 2'd2);
        step(1'b1, 2'd3);
        rd("drop_mem2", 3'd2, 8'hA5);
        rd("drop_mem5", 3'd5, 8'h3C);

        // Host write coincident with step 1: temp keeps the old word
        addr_a = 3'd2; addr_b = 3'd5;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
        step(1'b1, 2'd1); step(1'b1, 2'd2); step(1'b1, 2'd3);
        rd("coinc_temp_old", 3'd5, 8'hA5);
        rd("coinc_mem2", 3'd2, 8'h3C);

        // Coincident host write lands; w=0 mid-swap aborts with an error
        addr_a = 3'd2; addr_b = 3'd5;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
        step(1'b1, 2'd1);
        step(1'b0, 2'd0);
        chk("abort_err", seq_err, 1'b1);
        rd("coinc_lands", 3'd2, 8'h11);
        clear_err();

        // Randomized traffic, mostly well-formed sequences
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                w = 1'b1; sel = 2'(m_next);
            end else if (r < 8) begin
                w = 1'b0; sel = 2'($urandom_range(0, 3));
            end else begin
                w = 1'b1; sel = 2'($urandom_range(0, 3));
            end
            addr_a  = 3'($urandom_range(0, 7));
            addr_b  = 3'($urandom_range(0, 7));
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom_range(0, 255));
            rd_addr = 3'($urandom_range(0, 7));
            clr_err = ($urandom_range(0, 15) == 0);
            tick();
        end
        w = 1'b0; sel = 2'd0; wr_en = 1'b0; clr_err = 1'b0;
        clear_err();

        // Reset between steps 2 and 3 abandons the swap entirely
        hwrite(3'd3, 8'h5A);
        swap(3'd3, 3'd6);
        addr_a = 3'd3; addr_b = 3'd7;
        step(1'b1, 2'd1); step(1'b1, 2'd2);
        reset_n = 1'b0;
        #2;
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_done", done, 1'b0);
        chk("midreset_err", seq_err, 1'b0);
        chk("midreset_rd", rd_data, 8'h00);
        model_reset();
        #1 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) rd("midreset_word", 3'(i), 8'h00);

        // Three clean swaps after reset
        swap(3'd1, 3'd2); step(1'b0, 2'd0);
        swap(3'd3, 3'd4); step(1'b0, 2'd0);
        swap(3'd5, 3'd6); step(1'b0, 2'd0);
`ifdef SWAP_COUNT_EN
        chk("count_three", swap_count, 16'd3);
`endif
        chk("final_err", seq_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
